// File: rtl/note_sequencer.sv
// Score player: steps a {note, dur} ROM, times each note in ticks and strobes note codes to the audio block.
// Optional NOTE_SEQ_ARTIC_EN inserts a one-tick silence at the end of every non-rest note with dur >= 2.
module note_sequencer #(
    parameter int TICK_CYCLES = 6_250_000,
    parameter int SONG_LEN    = 32,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [3:0]        note,
    output logic              note_en,
    output logic              busy,
    output logic              song_done,
    output logic [ADDR_W-1:0] addr
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_STROBE  = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_SILENCE = 3'd4;
    localparam int CW = $clog2(15 * TICK_CYCLES + 1);

    // Handshake: start is accepted only in IDLE with stop low; stop wins in any busy
    // state except SILENCE; note_en is a 2-cycle pulse whose rising edge latches note.
    logic [2:0]        state;
    logic [3:0]        dur_q;
    logic [CW-1:0]     cnt;
    logic [1:0]        strb;
    logic [ADDR_W-1:0] nxt_addr;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_entry;
    logic [CW-1:0]     hold_last;
    logic              is_end;
    logic              hold_end;

    function automatic logic [7:0] rom(input logic [ADDR_W-1:0] a);
        case (a)
            ADDR_W'(0): rom = 8'h12;
            ADDR_W'(1): rom = 8'h21;
            ADDR_W'(2): rom = 8'hB3;
            ADDR_W'(3): rom = 8'h02;
            ADDR_W'(4): rom = 8'h00;
            default:    rom = 8'h00;
        endcase
    endfunction

    assign nxt_addr  = addr + 1'b1;
    assign hold_last = CW'(dur_q) * CW'(TICK_CYCLES) - CW'(1);
    assign hold_end  = (state == S_HOLD) && (cnt == hold_last);

    // LOAD reads the current entry; the end of HOLD folds the load of the next entry in.
    always_comb begin
        sel_addr  = addr;
        sel_entry = rom(addr);
        is_end    = 1'b0;
        if (state == S_HOLD) begin
            sel_addr  = nxt_addr;
            sel_entry = rom(nxt_addr);
            is_end    = (addr == ADDR_W'(SONG_LEN - 1));
        end
        if (sel_entry[3:0] == 4'd0) is_end = 1'b1;
    end

`ifdef NOTE_SEQ_ARTIC_EN
    logic [CW-1:0] gap_cnt;
    assign gap_cnt = CW'(dur_q - 4'd1) * CW'(TICK_CYCLES) - CW'(1);
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            note      <= 4'd0;
            note_en   <= 1'b0;
            busy      <= 1'b0;
            song_done <= 1'b0;
            addr      <= '0;
            dur_q     <= 4'd0;
            cnt       <= '0;
            strb      <= 2'b00;
        end else begin
            song_done <= 1'b0;
            note_en   <= strb[0];
            strb      <= strb >> 1;
            if (state != S_IDLE) cnt <= cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                        addr  <= '0;
                    end
                end
                S_SILENCE: begin
                    if (strb == 2'b00) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        addr  <= '0;
                    end
                end
                default: begin
                    if (stop) begin
                        note    <= 4'd0;
                        strb    <= 2'b11;
                        note_en <= 1'b0;
                        state   <= S_SILENCE;
                    end else if (state == S_LOAD || hold_end) begin
                        if (is_end) begin
                            song_done <= 1'b1;
                            if (loop_en) begin
                                addr  <= '0;
                                state <= S_LOAD;
                            end else begin
                                addr    <= sel_addr;
                                note    <= 4'd0;
                                strb    <= 2'b11;
                                note_en <= 1'b0;
                                state   <= S_SILENCE;
                            end
                        end else begin
                            note    <= sel_entry[7:4];
                            dur_q   <= sel_entry[3:0];
                            cnt     <= '0;
                            addr    <= sel_addr;
                            strb    <= 2'b11;
                            note_en <= 1'b0;
                            state   <= S_STROBE;
                        end
                    end else begin
                        if (state == S_STROBE && strb == 2'b00) state <= S_HOLD;
`ifdef NOTE_SEQ_ARTIC_EN
                        if (state == S_HOLD && dur_q >= 4'd2 && note != 4'd0 && cnt == gap_cnt) begin
                            note    <= 4'd0;
                            strb    <= 2'b11;
                            note_en <= 1'b0;
                        end
`endif
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: per-edge comparison against a timeline model built from the score rules.
module tb_note_sequencer;
    localparam int T    = 4;
    localparam int MAXE = 256;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic [3:0] note;
    logic       note_en;
    logic       busy;
    logic       song_done;
    logic [4:0] addr;

    int checks = 0;
    int errors = 0;

    logic [7:0] song [0:31];
    logic [3:0] m_note [0:MAXE-1];
    logic [4:0] m_addr [0:MAXE-1];
    logic       m_en   [0:MAXE-1];
    logic       m_busy [0:MAXE-1];
    logic       m_done [0:MAXE-1];

    note_sequencer #(.TICK_CYCLES(T), .SONG_LEN(32), .ADDR_W(5)) dut (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop), .loop_en(loop_en),
        .note(note), .note_en(note_en), .busy(busy), .song_done(song_done), .addr(addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Timeline of the song with start sampled at edge 0 and stop sampled at edge ks (<0: none).
    task automatic build(input int ks, input bit lp, output int h);
        bit         nv [0:MAXE-1];
        logic [3:0] nn [0:MAXE-1];
        bit         av [0:MAXE-1];
        logic [4:0] aa [0:MAXE-1];
        int cur, a, d, sil;
        bit wrap_end;
        logic [3:0] cn;
        logic [4:0] ca;
        for (int e = 0; e < MAXE; e++) begin
            nv[e] = 0; nn[e] = 0; av[e] = 0; aa[e] = 0; m_done[e] = 0;
        end
        cur = 1; a = 0; sil = -1; wrap_end = 0;
        while (sil < 0 && cur < MAXE - 80) begin
            d = wrap_end ? 0 : int'(song[a][3:0]);
            if (d == 0) begin
                m_done[cur] = 1;
                wrap_end = 0;
                if (lp) begin
                    av[cur] = 1; aa[cur] = 0; a = 0; cur = cur + 1;
                end else begin
                    av[cur] = 1; aa[cur] = 5'(a); sil = cur;
                end
            end else begin
                nv[cur] = 1; nn[cur] = song[a][7:4]; av[cur] = 1; aa[cur] = 5'(a);
`ifdef NOTE_SEQ_ARTIC_EN
                if (d >= 2 && song[a][7:4] != 4'd0) begin
                    nv[cur + (d - 1) * T] = 1; nn[cur + (d - 1) * T] = 4'd0;
                end
`endif
                cur = cur + d * T;
                a = (a + 1) % 32;
                if (a == 0) wrap_end = 1;
            end
        end
        if (ks >= 1 && (sil < 0 || ks <= sil)) begin
            for (int e = ks; e < MAXE; e++) begin
                nv[e] = 0; av[e] = 0; m_done[e] = 0;
            end
            sil = ks;
        end
        nv[sil] = 1; nn[sil] = 4'd0;
        h = sil + 5;
        cn = 0; ca = 0;
        for (int e = 0; e <= h; e++) begin
            if (nv[e]) cn = nn[e];
            if (av[e]) ca = aa[e];
            m_busy[e] = (e < sil + 3);
            if (!m_busy[e]) ca = 0;
            m_note[e] = cn;
            m_addr[e] = ca;
            m_en[e] = ((e >= 1 && nv[e-1]) || (e >= 2 && nv[e-2])) && !nv[e];
        end
    endtask

    task automatic run_scn(input int ks, input bit lp, input bit rnd, input int rst_at);
        int h;
        build(ks, lp, h);
        loop_en = lp;
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b0;
        for (int e = 0; e <= h; e++) begin
            @(posedge clk);
            #1;
            if (rst_at >= 0 && e == rst_at) begin
                chk($sformatf("rst_note@%0d", e), {4'd0, note}, 8'd0);
                chk($sformatf("rst_en@%0d", e), {7'd0, note_en}, 8'd0);
                chk($sformatf("rst_busy@%0d", e), {7'd0, busy}, 8'd0);
                chk($sformatf("rst_done@%0d", e), {7'd0, song_done}, 8'd0);
                chk($sformatf("rst_addr@%0d", e), {3'd0, addr}, 8'd0);
                rstn = 1'b1; start = 1'b0; stop = 1'b0;
                return;
            end
            chk($sformatf("note@%0d", e), {4'd0, note}, {4'd0, m_note[e]});
            chk($sformatf("note_en@%0d", e), {7'd0, note_en}, {7'd0, m_en[e]});
            chk($sformatf("busy@%0d", e), {7'd0, busy}, {7'd0, m_busy[e]});
            chk($sformatf("song_done@%0d", e), {7'd0, song_done}, {7'd0, m_done[e]});
            chk($sformatf("addr@%0d", e), {3'd0, addr}, {3'd0, m_addr[e]});
            start = (rnd && m_busy[e]) ? 1'($urandom_range(0, 1)) : 1'b0;
            stop  = (e + 1 == ks);
            if (rst_at >= 0 && e + 1 == rst_at) rstn = 1'b0;
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        int ks;
        bit lp;
        for (int i = 0; i < 32; i++) song[i] = 8'h00;
        song[0] = 8'h12; song[1] = 8'h21; song[2] = 8'hB3; song[3] = 8'h02; song[4] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_note", {4'd0, note}, 8'd0);
        chk("reset_en", {7'd0, note_en}, 8'd0);
        chk("reset_busy", {7'd0, busy}, 8'd0);
        chk("reset_done", {7'd0, song_done}, 8'd0);
        chk("reset_addr", {3'd0, addr}, 8'd0);
        rstn = 1'b1;
        @(posedge clk);

        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("startstop_busy", {7'd0, busy}, 8'd0);
            chk("startstop_note", {4'd0, note}, 8'd0);
        end

        run_scn(-1, 1'b0, 1'b0, -1);
        run_scn(70, 1'b1, 1'b0, -1);
        run_scn(12, 1'b0, 1'b0, -1);
        run_scn(-1, 1'b0, 1'b0, 10);
        run_scn(-1, 1'b0, 1'b1, -1);

        for (int n = 0; n < 8; n++) begin
            lp = 1'($urandom_range(0, 1));
            if (lp) ks = int'($urandom_range(1, 120));
            else if ($urandom_range(0, 1) == 1) ks = int'($urandom_range(1, 40));
            else ks = -1;
            run_scn(ks, lp, 1'b1, -1);
            repeat (2) @(posedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
